// File: rtl/wm_phase_timer.sv
// Phase-duration timer for the washing-machine controller: loads a per-phase
// tick count on entry to a timed phase and pulses sig_Time_Out once on expiry.
module wm_phase_timer #(
   parameter int CNT_W    = 8,
   parameter int PRESCALE = 4,
   parameter int T_SOAK   = 6,
   parameter int T_WASH   = 10,
   parameter int T_RINSE  = 8,
   parameter int T_SPIN   = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [2:0]       state,
   input  logic             sig_Lid_Closed,
   input  logic             sig_Cancel,
   output logic             sig_Time_Out,
   output logic [CNT_W-1:0] remaining,
   output logic             timer_running
);

   localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} fsm_t;

   fsm_t             fsm;
   logic [2:0]       state_q;
   logic [PS_W-1:0]  ps_cnt;
   logic             phase_change;
   logic             phase_timed;
   logic             tick;
   logic [CNT_W-1:0] load_val;

   // A zero-length phase still needs one tick so the controller gets its pulse.
   function automatic logic [CNT_W-1:0] dur(input int t);
      return (t <= 0) ? CNT_W'(1) : CNT_W'(t);
   endfunction

   // NOTE: both outputs get a default before the case, so no path leaves a latch.
   always_comb begin
      phase_timed = 1'b1;
      load_val    = '0;
      case (state)
         3'd2:    load_val = dur(T_SOAK);
         3'd3:    load_val = dur(T_WASH);
         3'd4:    load_val = dur(T_RINSE);
         3'd5:    load_val = dur(T_SPIN);
         default: phase_timed = 1'b0;
      endcase
   end

   assign phase_change = (state != state_q);
   assign tick         = (ps_cnt == PS_LAST);

   // NOTE: all state and outputs update with <= so every branch sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         fsm           <= IDLE;
         state_q       <= 3'd0;
         ps_cnt        <= '0;
         remaining     <= '0;
         sig_Time_Out  <= 1'b0;
         timer_running <= 1'b0;
      end else begin
         state_q      <= state;
         sig_Time_Out <= 1'b0;
         if (sig_Cancel) begin
            fsm           <= IDLE;
            ps_cnt        <= '0;
            remaining     <= '0;
            timer_running <= 1'b0;
         end else if (phase_change) begin
            // Untimed phases load zero from the decode above.
            ps_cnt    <= '0;
            remaining <= load_val;
            if (!phase_timed) begin
               fsm           <= IDLE;
               timer_running <= 1'b0;
            end else if (sig_Lid_Closed) begin
               fsm           <= RUN;
               timer_running <= 1'b1;
            end else begin
               fsm           <= PAUSE;
               timer_running <= 1'b0;
            end
         end else begin
            case (fsm)
               // Resuming from PAUSE counts on the same cycle the lid closes,
               // so the pulse slips by exactly the number of open-lid cycles.
               RUN, PAUSE: begin
                  if (!sig_Lid_Closed) begin
                     fsm           <= PAUSE;
                     timer_running <= 1'b0;
                  end else if (tick) begin
                     ps_cnt <= '0;
                     if (remaining <= CNT_W'(1)) begin
                        remaining     <= '0;
                        sig_Time_Out  <= 1'b1;
                        fsm           <= EXPIRED;
                        timer_running <= 1'b0;
                     end else begin
                        remaining     <= remaining - CNT_W'(1);
                        fsm           <= RUN;
                        timer_running <= 1'b1;
                     end
                  end else begin
                     ps_cnt        <= ps_cnt + PS_W'(1);
                     fsm           <= RUN;
                     timer_running <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wm_phase_timer.sv
// Scenario bench for wm_phase_timer: expected pulse cycles are queued when a
// phase is entered and matched against pulses captured by a monitor.
module tb_wm_phase_timer;

   localparam int CNT_W    = 8;
   localparam int PRESCALE = 2;
   localparam int T_WASH   = 5;
   localparam int T_RINSE  = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [2:0]       state = 3'd0;
   logic             sig_Lid_Closed = 1'b1;
   logic             sig_Cancel = 1'b0;
   logic             sig_Time_Out;
   logic [CNT_W-1:0] remaining;
   logic             timer_running;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_q[$];
   int obs_q[$];

   wm_phase_timer #(
      .CNT_W(CNT_W), .PRESCALE(PRESCALE), .T_SOAK(6),
      .T_WASH(T_WASH), .T_RINSE(T_RINSE), .T_SPIN(5)
   ) dut (
      .clock(clock), .reset(reset), .state(state),
      .sig_Lid_Closed(sig_Lid_Closed), .sig_Cancel(sig_Cancel),
      .sig_Time_Out(sig_Time_Out), .remaining(remaining),
      .timer_running(timer_running)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) if (sig_Time_Out === 1'b1) obs_q.push_back(cyc);

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   // Park in ready, then step into the phase; c0 is the cycle the load shows.
   task automatic enter_phase(input logic [2:0] ph, output int c0);
      state = 3'd1;
      cycles(2);
      state = ph;
      cycles(1);
      c0 = cyc;
   endtask

   task automatic test_reset();
      int c0;
      cycles(2);
      n_checks++;
      if (remaining !== 8'd0 || timer_running !== 1'b0 || sig_Time_Out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_init: rem=%0d run=%b to=%b, want 0/0/0", remaining, timer_running, sig_Time_Out);
      end
      reset = 1'b0;
      enter_phase(3'd3, c0);
      cycles(4);
      n_checks++;
      if (remaining !== 8'd3) begin
         n_fail++;
         $display("FAIL reset_precount: rem=%0d, want 3", remaining);
      end
      reset = 1'b1;
      state = 3'd0;
      cycles(1);
      n_checks++;
      if (remaining !== 8'd0 || timer_running !== 1'b0 || sig_Time_Out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: rem=%0d run=%b to=%b, want 0/0/0", remaining, timer_running, sig_Time_Out);
      end
      reset = 1'b0;
      cycles(40);
      n_checks++;
      if (obs_q.size() != 0 || remaining !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_no_pulse: pulses=%0d rem=%0d, want 0/0", obs_q.size(), remaining);
      end
      obs_q.delete();
   endtask

   task automatic test_nominal();
      int c0, p, e;
      enter_phase(3'd3, c0);
      exp_q.push_back(c0 + PRESCALE * T_WASH);
      n_checks++;
      if (remaining !== 8'(T_WASH) || timer_running !== 1'b1) begin
         n_fail++;
         $display("FAIL nominal_load: rem=%0d run=%b, want %0d/1", remaining, timer_running, T_WASH);
      end
      cycles(PRESCALE);
      n_checks++;
      if (remaining !== 8'(T_WASH - 1)) begin
         n_fail++;
         $display("FAIL nominal_dec: rem=%0d, want %0d", remaining, T_WASH - 1);
      end
      for (int i = 0; i < 60 && obs_q.size() == 0; i++) cycles(1);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL nominal_pulse: no pulse seen, want cycle %0d", e);
      end else begin
         p = obs_q.pop_front();
         if (p != e) begin
            n_fail++;
            $display("FAIL nominal_pulse: pulse at cycle %0d, want %0d", p, e);
         end
      end
      n_checks++;
      if (remaining !== 8'd0 || timer_running !== 1'b0) begin
         n_fail++;
         $display("FAIL nominal_expired: rem=%0d run=%b, want 0/0", remaining, timer_running);
      end
      cycles(1);
      n_checks++;
      if (sig_Time_Out !== 1'b0) begin
         n_fail++;
         $display("FAIL nominal_width: to=%b one cycle later, want 0", sig_Time_Out);
      end
      cycles(30);
      n_checks++;
      if (obs_q.size() != 0 || remaining !== 8'd0) begin
         n_fail++;
         $display("FAIL nominal_hold: extra pulses=%0d rem=%0d, want 0/0", obs_q.size(), remaining);
      end
      obs_q.delete();
   endtask

   task automatic test_lid_pause();
      int c0, p, e;
      enter_phase(3'd3, c0);
      cycles(4);
      sig_Lid_Closed = 1'b0;
      exp_q.push_back(c0 + PRESCALE * T_WASH + 7);
      cycles(1);
      n_checks++;
      if (remaining !== 8'd3 || timer_running !== 1'b0) begin
         n_fail++;
         $display("FAIL pause_enter: rem=%0d run=%b, want 3/0", remaining, timer_running);
      end
      cycles(6);
      n_checks++;
      if (remaining !== 8'd3 || timer_running !== 1'b0) begin
         n_fail++;
         $display("FAIL pause_frozen: rem=%0d run=%b, want 3/0", remaining, timer_running);
      end
      sig_Lid_Closed = 1'b1;
      cycles(1);
      n_checks++;
      if (timer_running !== 1'b1) begin
         n_fail++;
         $display("FAIL pause_resume: run=%b, want 1", timer_running);
      end
      for (int i = 0; i < 60 && obs_q.size() == 0; i++) cycles(1);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL pause_pulse: no pulse seen, want cycle %0d", e);
      end else begin
         p = obs_q.pop_front();
         if (p != e) begin
            n_fail++;
            $display("FAIL pause_pulse: pulse at cycle %0d, want %0d", p, e);
         end
      end
   endtask

   task automatic test_cancel();
      int c0;
      enter_phase(3'd4, c0);
      cycles(8);
      n_checks++;
      if (remaining !== 8'd4) begin
         n_fail++;
         $display("FAIL cancel_pre: rem=%0d, want 4", remaining);
      end
      sig_Cancel = 1'b1;
      cycles(1);
      sig_Cancel = 1'b0;
      n_checks++;
      if (remaining !== 8'd0 || timer_running !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel_clear: rem=%0d run=%b, want 0/0", remaining, timer_running);
      end
      cycles(100);
      n_checks++;
      if (obs_q.size() != 0 || remaining !== 8'd0) begin
         n_fail++;
         $display("FAIL cancel_no_pulse: pulses=%0d rem=%0d, want 0/0", obs_q.size(), remaining);
      end
      obs_q.delete();
   endtask

   task automatic test_phase_race();
      int c0;
      enter_phase(3'd3, c0);
      cycles(PRESCALE * T_WASH - 1);
      n_checks++;
      if (remaining !== 8'd1) begin
         n_fail++;
         $display("FAIL race_pre: rem=%0d, want 1", remaining);
      end
      state = 3'd4;
      cycles(1);
      n_checks++;
      if (remaining !== 8'(T_RINSE) || sig_Time_Out !== 1'b0 || timer_running !== 1'b1) begin
         n_fail++;
         $display("FAIL race_reload: rem=%0d to=%b run=%b, want %0d/0/1", remaining, sig_Time_Out, timer_running, T_RINSE);
      end
      cycles(5);
      n_checks++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL race_no_pulse: pulses=%0d, want 0", obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      int c0, c1, p, e;
      enter_phase(3'd3, c0);
      cycles(4);
      state = 3'd4;
      cycles(1);
      c1 = cyc;
      exp_q.push_back(c1 + PRESCALE * T_RINSE);
      n_checks++;
      if (remaining !== 8'(T_RINSE)) begin
         n_fail++;
         $display("FAIL b2b_reload: rem=%0d, want %0d", remaining, T_RINSE);
      end
      for (int i = 0; i < 60 && obs_q.size() == 0; i++) cycles(1);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL b2b_pulse: no pulse seen, want cycle %0d", e);
      end else begin
         p = obs_q.pop_front();
         if (p != e) begin
            n_fail++;
            $display("FAIL b2b_pulse: pulse at cycle %0d, want %0d", p, e);
         end
      end
   endtask

   task automatic test_untimed();
      state = 3'd6;
      for (int i = 0; i < 200; i++) begin
         cycles(1);
         n_checks++;
         if (remaining !== 8'd0 || timer_running !== 1'b0 || sig_Time_Out !== 1'b0) begin
            n_fail++;
            $display("FAIL untimed_%0d: rem=%0d run=%b to=%b, want 0/0/0", i, remaining, timer_running, sig_Time_Out);
         end
      end
      n_checks++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL untimed_no_pulse: pulses=%0d, want 0", obs_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_lid_pause();
      test_cancel();
      test_phase_race();
      test_back_to_back();
      test_untimed();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
